// File: rtl/fan_packet_engine.sv
// Pulse-coded packet transmitter for the fan remote: preamble, ID and command,
// three equal slots per bit (low / data / high), with repeats, gaps and abort.
module fan_packet_engine #(
  parameter int unsigned PHASE_CYCLES  = 1836,
  parameter int unsigned PREAMBLE_BITS = 2,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned CMD_WIDTH     = 7,
  parameter int unsigned REPEAT_WIDTH  = 4,
  parameter int unsigned GAP_CYCLES    = 11016,
  parameter int unsigned MSB_FIRST     = 0
) (
  input  logic                    ref_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ID_WIDTH-1:0]     id,
  input  logic [CMD_WIDTH-1:0]    cmd,
  input  logic [REPEAT_WIDTH-1:0] repeats,
  output logic                    out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NBITS = PREAMBLE_BITS + ID_WIDTH + CMD_WIDTH;
  localparam int unsigned PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [1:0]              slot_q, slot_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  logic                    out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [ID_WIDTH-1:0]     id_ord;
  logic [CMD_WIDTH-1:0]    cmd_ord;
  logic [NBITS-1:0]        pkt_bits;

  // pkt_bits[b] is the data value carried in slot 1 of transmitted bit b.
  for (genvar gi = 0; gi < ID_WIDTH; gi++) begin : g_id_ord
    if (MSB_FIRST != 0) begin : g_msb
      assign id_ord[gi] = id_q[ID_WIDTH-1-gi];
    end else begin : g_lsb
      assign id_ord[gi] = id_q[gi];
    end
  end

  for (genvar gc = 0; gc < CMD_WIDTH; gc++) begin : g_cmd_ord
    if (MSB_FIRST != 0) begin : g_msb
      assign cmd_ord[gc] = cmd_q[CMD_WIDTH-1-gc];
    end else begin : g_lsb
      assign cmd_ord[gc] = cmd_q[gc];
    end
  end

  for (genvar gb = 0; gb < NBITS; gb++) begin : g_pkt
    if (gb < PREAMBLE_BITS) begin : g_pre
      assign pkt_bits[gb] = 1'b0;
    end else if (gb < PREAMBLE_BITS + ID_WIDTH) begin : g_id
      assign pkt_bits[gb] = id_ord[gb-PREAMBLE_BITS];
    end else begin : g_cmd
      assign pkt_bits[gb] = cmd_ord[gb-PREAMBLE_BITS-ID_WIDTH];
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      slot_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      id_q    <= '0;
      cmd_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          id_d    = id;
          cmd_d   = cmd;
          rep_d   = repeats;
          phase_d = '0;
          slot_d  = '0;
          bit_d   = '0;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          slot_d  = '0;
          bit_d   = '0;
        end else if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          if (slot_q != 2'd2) begin
            slot_d = slot_q + 2'd1;
          end else begin
            slot_d = '0;
            if (bit_q != BIT_LAST) begin
              bit_d = bit_q + 1'b1;
            end else begin
              bit_d = '0;
              if (rep_q != '0) begin
                rep_d   = rep_q - 1'b1;
                gap_d   = '0;
                state_d = GAP;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          gap_d   = '0;
        end else if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end else begin
          gap_d   = '0;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line is aligned
  // with the state it describes.
  always_comb begin
    busy_d = (state_d != IDLE);
    out_d  = 1'b0;
    if (state_d == SEND) begin
      unique case (slot_d)
        2'd1:    out_d = pkt_bits[bit_d];
        2'd2:    out_d = 1'b1;
        default: out_d = 1'b0;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fan_packet_engine.sv
// Randomised scoreboard bench for fan_packet_engine: expected per-cycle
// out/busy/done samples are queued by the driver and popped by the monitor.
module tb_fan_packet_engine;

  localparam int PC   = 4;
  localparam int PRE  = 2;
  localparam int IDW  = 4;
  localparam int CMDW = 7;
  localparam int RW   = 4;
  localparam int GAPC = 8;
  localparam int MSBF = 0;
  localparam int NB   = PRE + IDW + CMDW;

  logic            ref_clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [IDW-1:0]  id;
  logic [CMDW-1:0] cmd;
  logic [RW-1:0]   repeats;
  logic            out;
  logic            busy;
  logic            done;

  typedef struct packed {
    logic o;
    logic b;
    logic d;
  } sample_t;

  sample_t     exp_q[$];
  int unsigned n_cmp    = 0;
  int unsigned n_bad    = 0;
  int unsigned cyc      = 0;
  logic        cur_busy = 1'b0;

  fan_packet_engine #(
    .PHASE_CYCLES (PC),
    .PREAMBLE_BITS(PRE),
    .ID_WIDTH     (IDW),
    .CMD_WIDTH    (CMDW),
    .REPEAT_WIDTH (RW),
    .GAP_CYCLES   (GAPC),
    .MSB_FIRST    (MSBF)
  ) dut (
    .ref_clk(ref_clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .id     (id),
    .cmd    (cmd),
    .repeats(repeats),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  always #5 ref_clk = ~ref_clk;

  function automatic logic data_bit(input logic [IDW-1:0] i, input logic [CMDW-1:0] c,
                                    input int b);
    int k;
    if (b < PRE) return 1'b0;
    if (b < PRE + IDW) begin
      k = b - PRE;
      return (MSBF != 0) ? i[IDW-1-k] : i[k];
    end
    k = b - PRE - IDW;
    return (MSBF != 0) ? c[CMDW-1-k] : c[k];
  endfunction

  task automatic push_run(input logic [IDW-1:0] i, input logic [CMDW-1:0] c,
                          input logic [RW-1:0] r);
    logic lvl;
    for (int p = 0; p <= int'(r); p++) begin
      for (int b = 0; b < NB; b++) begin
        for (int s = 0; s < 3; s++) begin
          lvl = (s == 0) ? 1'b0 : (s == 1) ? data_bit(i, c, b) : 1'b1;
          repeat (PC) exp_q.push_back({lvl, 1'b1, 1'b0});
        end
      end
      if (p < int'(r)) repeat (GAPC) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  // One clock edge: apply inputs, advance the reference model, wait past the edge.
  task automatic step(input logic rs, input logic ab, input logic st,
                      input logic [IDW-1:0] i, input logic [CMDW-1:0] c,
                      input logic [RW-1:0] r);
    reset   = rs;
    abort   = ab;
    start   = st;
    id      = i;
    cmd     = c;
    repeats = r;
    if (rs) begin
      exp_q.delete();
      exp_q.push_back(3'b000);
    end else if (cur_busy) begin
      if (ab) begin
        exp_q.delete();
        exp_q.push_back(3'b000);
      end
    end else if (st) begin
      push_run(i, c, r);
    end else begin
      exp_q.push_back(3'b000);
    end
    @(negedge ref_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, IDW'($urandom), CMDW'($urandom), RW'($urandom));
  endtask

  task automatic check(input string nm, input logic got, input logic expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", nm, cyc, got, expv);
    end
  endtask

  initial begin : monitor
    sample_t s;
    forever begin
      @(negedge ref_clk);
      cyc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow cycle %0d: got out=%0b busy=%0b done=%0b expected queued sample",
                 cyc, out, busy, done);
        cur_busy = 1'b0;
      end else begin
        s = exp_q.pop_front();
        check("out", out, s.o);
        check("busy", busy, s.b);
        check("done", done, s.d);
        cur_busy = s.b;
      end
    end
  end

  initial begin : driver
    int unsigned k;
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(2);

    // single packet with a foreign start mid-packet that must be ignored
    step(1'b0, 1'b0, 1'b1, 4'b1010, 7'b0010111, 4'd0);
    idle(49);
    step(1'b0, 1'b0, 1'b1, 4'b0101, 7'b1100000, 4'd3);
    idle(150);

    // repeats=2
    step(1'b0, 1'b0, 1'b1, 4'b1010, 7'b0010111, 4'd2);
    idle(500);

    // abort mid-packet, then restart
    step(1'b0, 1'b0, 1'b1, 4'b1010, 7'b0010111, 4'd0);
    idle(59);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 4'b0110, 7'b1011001, 4'd0);
    idle(200);

    // reset mid-packet, then restart
    step(1'b0, 1'b0, 1'b1, 4'b1010, 7'b0010111, 4'd1);
    idle(99);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 7'b0000001, 4'd0);
    idle(200);

    // start held high: back-to-back runs
    repeat (400) step(1'b0, 1'b0, 1'b1, IDW'($urandom), CMDW'($urandom), RW'($urandom_range(0, 1)));

    // random traffic
    repeat (4000)
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 19) == 0, IDW'($urandom), CMDW'($urandom),
           RW'($urandom_range(0, 3)));

    k = 0;
    while (cur_busy && k < 3000) begin
      idle(1);
      k++;
    end
    if (cur_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", k);
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fan_packet_engine.md
# fan_packet_engine

Parametrised transmitter for the fan remote's pulse-coded packet. It serialises a preamble, a device ID and a command word onto a single output line, using three equal-length slots per bit: low, then data, then high. It adds runtime ID/command inputs, configurable field widths and timing, automatic packet repetition with inter-packet gaps, a busy/done handshake and abort. It sits between the control logic and the RF/IR modulator driver, clocked by the reference clock.

## Interface
- PHASE_CYCLES, 1836: ref_clk cycles per slot (≥2)
- PREAMBLE_BITS, 2: leading zero bits per packet (≥0)
- ID_WIDTH, 4: ID field width (≥1)
- CMD_WIDTH, 7: command field width (≥1)
- REPEAT_WIDTH, 4: width of repeat count input
- GAP_CYCLES, 11016: low cycles between repeated packets (≥1)
- MSB_FIRST, 0: 0 = ID and command sent LSB first; 1 = MSB first
- ref_clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  single-cycle request; accepted only when busy=0
- abort  in  1  stop transmission immediately
- id  in  ID_WIDTH  device ID, sampled on accepted start
- cmd  in  CMD_WIDTH  command, sampled on accepted start
- repeats  in  REPEAT_WIDTH  extra copies; sends repeats+1 packets; sampled on accepted start
- out  out  1  serial line, idle low
- busy  out  1  high from the cycle after start acceptance until completion/abort
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, SEND, GAP.
- Packet = PREAMBLE_BITS zeros, then id, then cmd. NBITS = PREAMBLE_BITS+ID_WIDTH+CMD_WIDTH.
- Each bit is slots 0/1/2. Slot 0: out=0. Slot 1: out=bit value. Slot 2: out=1. Each slot lasts exactly PHASE_CYCLES cycles.
- IDLE: out=0, busy=0. start=1 → latch id, cmd, repeats; load rep_left=repeats; go to SEND at bit 0, slot 0, phase counter 0.
- SEND: phase counter runs 0..PHASE_CYCLES-1. At wrap, advance slot. After slot 2, advance bit.
  - After slot 2 of bit NBITS-1: if rep_left≠0, decrement it and go to GAP. Otherwise go to IDLE and pulse done.
- GAP: out=0 for GAP_CYCLES cycles, then SEND at bit 0, slot 0, using the same latched fields.
- Input changes on id/cmd/repeats while busy have no effect.
- start while busy is ignored and is not queued.
- abort while busy → IDLE next cycle: out=0, busy=0, no done pulse. abort in IDLE has no effect.
- Priority: reset > abort > start.
- reset: state=IDLE; out=0, busy=0, done=0; all counters and latched fields cleared. Reset mid-packet truncates the packet with no done pulse.
- Counter widths come from $clog2 of each bound. There is no arithmetic overflow, because every counter compares against its terminal value before wrapping.

## Timing
- Start accepted at edge T → from T+1: busy=1, out=0 (bit 0, slot 0).
- Packet duration P = NBITS·3·PHASE_CYCLES cycles. Slot k (0-based, across the packet) occupies cycles T+1+k·PHASE_CYCLES … T+(k+1)·PHASE_CYCLES.
- Total transmission = (repeats+1)·P + repeats·GAP_CYCLES cycles. Its final high slot ends at cycle E = T + that total.
- At E+1: out=0, busy=0, done=1 for exactly one cycle.
- A start at E+1 is accepted, giving back-to-back operation with only the one-cycle low between runs.
- abort sampled at edge A → out=0 and busy=0 from A+1.
- out and busy are registered outputs with no combinational path from inputs.

## Test plan
All scenarios use PHASE_CYCLES=4, PREAMBLE_BITS=2, ID_WIDTH=4, CMD_WIDTH=7, GAP_CYCLES=8, MSB_FIRST=0. This gives NBITS=13 and P=156.
- Single packet: id=4'b1010, cmd=7'b0010111, repeats=0, start at T → busy rises at T+1.
  - Slot-1 levels across bits are 0,0,0,1,0,1,1,1,1,0,1,0,0.
  - done pulses at T+157; busy=0 from T+157.
- Repeat: repeats=2 → three identical 156-cycle packets, each pair separated by 8 low cycles. done at T+1+3·156+2·8 = T+485; exactly one done pulse.
- Ignore start while busy: pulse start with different id at T+50 → waveform is bit-identical to the single-packet run.
- Abort: abort at T+60 → out=0 and busy=0 at T+61; done is never asserted; a new start at T+70 transmits a full packet.
- Reset mid-operation: reset at T+100 → at T+101 out=0, busy=0, done=0, state IDLE; the following start behaves as from power-up.
- Back-to-back: start held at the done cycle → second packet begins the next cycle. MSB_FIRST=1 build: the same id/cmd yields ID slot-1 levels 1,0,1,0.
